ts_packet_generator: RTL and testbench

- Source end of the MPEG2-TS interface monitored by packet_loss_counter.
- Emits a byte-serial 188-byte TS packet stream on valid/sync/data with a fixed PID and a continuity counter (CC) that increments per packet.
- Supports controlled CC-skip injection, so a test rig can drive the loss counters with a known error count.
- Instantiated once per monitored channel in test and loopback setups.

---
 rtl/ts_packet_generator.sv | 154 +++++++++++++++
 tb/tb_ts_packet_generator.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_generator.sv
// MPEG2-TS packet source: byte-serial 188-byte packets with fixed PID,
// a per-packet continuity counter and on-demand CC-skip injection.
module ts_packet_generator #(
  parameter logic [12:0] PID     = 13'h0100,
  parameter int unsigned PKT_LEN = 188,
  parameter int unsigned GAP     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        skip_req,
  output logic        valid,
  output logic        sync,
  output logic [7:0]  data,
  output logic        busy,
  output logic [31:0] packet_count
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(3);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;
  logic             emit_c;
  logic             last_sel_c;
  logic [7:0]       byte_c;
  logic             last_out;
  logic [3:0]       cc;
  logic             skip_pending;
  logic             skip_c;

  // State, byte index and gap counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      gap_cnt <= gap_next;
    end
  end

  // Next-state logic: selects the byte index that is emitted one clock later
  always_comb begin
    state_next = state;
    idx_next   = idx;
    gap_next   = gap_cnt;
    emit_c     = 1'b0;
    last_sel_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_next = S_HEADER;
          idx_next   = '0;
        end
      end
      S_HEADER: begin
        emit_c   = 1'b1;
        idx_next = idx + IDX_W'(1);
        if (idx == HDR_LAST) begin
          state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        emit_c = 1'b1;
        if (idx == LAST_IDX) begin
          last_sel_c = 1'b1;
          idx_next   = '0;
          gap_next   = '0;
          if (GAP == 0) begin
            state_next = enable ? S_HEADER : S_IDLE;
          end else begin
            state_next = S_GAP;
          end
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = enable ? S_HEADER : S_IDLE;
        end else begin
          gap_next = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Byte map: sync, PID, flags+CC, then an incrementing payload pattern
  always_comb begin
    byte_c = idx;
    case (idx)
      8'd0:    byte_c = 8'h47;
      8'd1:    byte_c = {3'b000, PID[12:8]};
      8'd2:    byte_c = PID[7:0];
      8'd3:    byte_c = {2'b00, 2'b01, cc};
      default: byte_c = idx;
    endcase
  end

  // Registered stream outputs; last_out marks the cycle the last byte is on the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      sync     <= 1'b0;
      data     <= 8'h00;
      busy     <= 1'b0;
      last_out <= 1'b0;
    end else begin
      valid    <= emit_c;
      sync     <= emit_c && (idx == '0);
      data     <= emit_c ? byte_c : 8'h00;
      busy     <= (state != S_IDLE);
      last_out <= last_sel_c;
    end
  end

  assign skip_c = skip_pending | skip_req;

  // Continuity counter, pending skip and packet counter advance at packet end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc           <= 4'd0;
      skip_pending <= 1'b0;
      packet_count <= 32'd0;
    end else if (last_out) begin
      cc           <= cc + (skip_c ? 4'd2 : 4'd1);
      skip_pending <= 1'b0;
      packet_count <= packet_count + 32'd1;
    end else if (skip_req) begin
      skip_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ts_packet_generator.sv
// Scoreboard bench for ts_packet_generator: expected bytes are queued per
// packet and compared against the stream as it is emitted.
module tb_ts_packet_generator;

  localparam int PLEN = 188;
  localparam int PGAP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        skip_req = 1'b0;
  logic        valid;
  logic        sync;
  logic [7:0]  data;
  logic        busy;
  logic [31:0] packet_count;

  logic        enable0 = 1'b0;
  logic        skip0 = 1'b0;
  logic        valid0;
  logic        sync0;
  logic [7:0]  data0;
  logic        busy0;
  logic [31:0] packet_count0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       s;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         mon_idx = 0;
  int         mon_pkts = 0;
  int         loss_count = 0;
  logic [3:0] prev_cc = 4'd0;
  bit         have_prev = 1'b0;

  ts_packet_generator #(.PID(13'h0100), .PKT_LEN(188), .GAP(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .skip_req(skip_req),
    .valid(valid), .sync(sync), .data(data), .busy(busy),
    .packet_count(packet_count)
  );

  ts_packet_generator #(.PID(13'h0100), .PKT_LEN(188), .GAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable0), .skip_req(skip0),
    .valid(valid0), .sync(sync0), .data(data0), .busy(busy0),
    .packet_count(packet_count0)
  );

  always #5 clk = ~clk;

  // Stream monitor: pops expected bytes and tracks CC continuity like a loss counter
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      mon_idx   = 0;
      have_prev = 1'b0;
    end else if (valid) begin
      if (sync) begin
        mon_idx = 0;
        mon_pkts++;
      end else begin
        mon_idx++;
      end
      if (mon_idx == 3) begin
        if (have_prev && data[3:0] != prev_cc + 4'd1) loss_count++;
        prev_cc   = data[3:0];
        have_prev = 1'b1;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL byte_stream: got data=%h sync=%b, expected no byte", data, sync);
      end else begin
        mon_e = exp_q.pop_front();
        if (data !== mon_e.d || sync !== mon_e.s) begin
          failures++;
          $display("FAIL byte_stream pkt %0d idx %0d: got data=%h sync=%b, expected data=%h sync=%b",
                   mon_pkts, mon_idx, data, sync, mon_e.d, mon_e.s);
        end
      end
    end else begin
      checks++;
      if (sync !== 1'b0) begin
        failures++;
        $display("FAIL idle_sync: got sync=%b, expected 0", sync);
      end
    end
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_packet(input logic [3:0] cc);
    exp_t e;
    for (int k = 0; k < PLEN; k++) begin
      e.s = (k == 0);
      case (k)
        0:       e.d = 8'h47;
        1:       e.d = 8'h01;
        2:       e.d = 8'h00;
        3:       e.d = {4'h1, cc};
        default: e.d = 8'(k);
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable   = 1'b0;
    skip_req = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    mon_pkts   = 0;
    loss_count = 0;
    @(negedge clk);
  endtask

  task automatic wait_pkts(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mon_pkts >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_packets(input int n, output bit ok);
    bit ok1;
    bit ok2;
    enable = 1'b1;
    wait_pkts(n, n * (PLEN + PGAP) + 50, ok1);
    enable = 1'b0;
    wait_idle(PLEN + PGAP + 50, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, sync, data, busy} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b sync=%b data=%h busy=%b, expected all 0", valid, sync, data, busy);
    end
    checks++;
    if (packet_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d, expected 0", packet_count);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_enable: got valid=%b busy=%b, expected 0 0", valid, busy);
    end
  endtask

  task automatic test_basic();
    int gap_run;
    int gaps[$];
    bit done;
    int quiet;
    do_reset();
    for (int i = 0; i < 3; i++) push_packet(4'(i));
    gap_run = 0;
    done    = 1'b0;
    enable  = 1'b1;
    for (int cyc = 0; cyc < 3 * (PLEN + PGAP) + 60 && !done; cyc++) begin
      @(negedge clk);
      if (mon_pkts >= 3) enable = 1'b0;
      if (valid) begin
        if (sync && mon_pkts > 1) gaps.push_back(gap_run);
        gap_run = 0;
      end else if (busy) begin
        gap_run++;
      end else if (mon_pkts >= 3) begin
        gaps.push_back(gap_run);
        done = 1'b1;
      end
    end
    enable = 1'b0;
    checks++;
    if (!done || gaps.size() != 3) begin
      failures++;
      $display("FAIL basic_done: got done=%b gaps=%0d, expected 1 and 3", done, gaps.size());
    end else begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (gaps[g] != PGAP) begin
          failures++;
          $display("FAIL basic_gap%0d: got %0d idle cycles, expected %0d", g, gaps[g], PGAP);
        end
      end
    end
    checks++;
    if (packet_count !== 32'd3) begin
      failures++;
      $display("FAIL basic_count: got %0d, expected 3", packet_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain: got %0d bytes outstanding, expected 0", exp_q.size());
    end
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid || busy) quiet++;
    end
    checks++;
    if (quiet != 0) begin
      failures++;
      $display("FAIL basic_idle: got %0d active cycles after stop, expected 0", quiet);
    end
  endtask

  task automatic test_continuous();
    bit ok;
    do_reset();
    for (int i = 0; i < 20; i++) push_packet(4'(i % 16));
    run_packets(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cont_timeout: got ok=0, expected 1");
    end
    checks++;
    if (packet_count !== 32'd20 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL cont_count: got count=%0d left=%0d, expected 20 0", packet_count, exp_q.size());
    end
    checks++;
    if (loss_count != 0) begin
      failures++;
      $display("FAIL cont_loss: got %0d, expected 0", loss_count);
    end
  endtask

  task automatic test_skip();
    bit done;
    bit ok;
    do_reset();
    push_packet(4'd0);
    push_packet(4'd1);
    push_packet(4'd2);
    push_packet(4'd4);
    push_packet(4'd6);
    done   = 1'b0;
    enable = 1'b1;
    for (int cyc = 0; cyc < 5 * (PLEN + PGAP) + 60 && !done; cyc++) begin
      @(negedge clk);
      if (valid && mon_pkts == 3 && mon_idx == 20) skip_req = 1'b1;
      else if (valid && mon_pkts == 4 && (mon_idx == 10 || mon_idx == 30)) skip_req = 1'b1;
      else skip_req = 1'b0;
      if (mon_pkts >= 5) enable = 1'b0;
      if (mon_pkts >= 5 && !busy) done = 1'b1;
    end
    enable   = 1'b0;
    skip_req = 1'b0;
    checks++;
    if (!done || packet_count !== 32'd5 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL skip_run: got done=%b count=%0d left=%0d, expected 1 5 0", done, packet_count, exp_q.size());
    end
    checks++;
    if (loss_count != 2) begin
      failures++;
      $display("FAIL skip_loss: got %0d, expected 2", loss_count);
    end
    // skip pulse while idle applies to the end of the next packet
    @(negedge clk);
    skip_req = 1'b1;
    @(negedge clk);
    skip_req = 1'b0;
    repeat (3) @(negedge clk);
    mon_pkts = 0;
    push_packet(4'd7);
    push_packet(4'd9);
    run_packets(2, ok);
    checks++;
    if (!ok || packet_count !== 32'd7 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL skip_idle: got ok=%b count=%0d left=%0d, expected 1 7 0", ok, packet_count, exp_q.size());
    end
    checks++;
    if (loss_count != 3) begin
      failures++;
      $display("FAIL skip_idle_loss: got %0d, expected 3", loss_count);
    end
  endtask

  task automatic test_skip_wrap();
    bit done;
    do_reset();
    for (int i = 0; i < 16; i++) push_packet(4'(i));
    push_packet(4'd1);
    done   = 1'b0;
    enable = 1'b1;
    for (int cyc = 0; cyc < 17 * (PLEN + PGAP) + 60 && !done; cyc++) begin
      @(negedge clk);
      if (valid && mon_pkts == 16 && mon_idx == PLEN - 1) skip_req = 1'b1;
      else skip_req = 1'b0;
      if (mon_pkts >= 17) enable = 1'b0;
      if (mon_pkts >= 17 && !busy) done = 1'b1;
    end
    enable   = 1'b0;
    skip_req = 1'b0;
    checks++;
    if (!done || packet_count !== 32'd17 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_run: got done=%b count=%0d left=%0d, expected 1 17 0", done, packet_count, exp_q.size());
    end
    checks++;
    if (loss_count != 1) begin
      failures++;
      $display("FAIL wrap_loss: got %0d, expected 1", loss_count);
    end
  endtask

  task automatic test_enable_drop();
    bit done;
    bit ok;
    int gap_run;
    int active;
    mon_pkts = 0;
    push_packet(4'd2);
    done    = 1'b0;
    gap_run = 0;
    enable  = 1'b1;
    for (int cyc = 0; cyc < PLEN + PGAP + 60 && !done; cyc++) begin
      @(negedge clk);
      if (valid && mon_pkts == 1 && mon_idx == 50) enable = 1'b0;
      if (valid) gap_run = 0;
      else if (busy) gap_run++;
      else if (mon_pkts >= 1) done = 1'b1;
    end
    enable = 1'b0;
    checks++;
    if (!done || exp_q.size() != 0 || packet_count !== 32'd18) begin
      failures++;
      $display("FAIL drop_complete: got done=%b left=%0d count=%0d, expected 1 0 18", done, exp_q.size(), packet_count);
    end
    checks++;
    if (gap_run != PGAP) begin
      failures++;
      $display("FAIL drop_gap: got %0d trailing idle cycles, expected %0d", gap_run, PGAP);
    end
    active = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid || busy) active++;
    end
    checks++;
    if (active != 0) begin
      failures++;
      $display("FAIL drop_idle: got %0d active cycles, expected 0", active);
    end
    push_packet(4'd3);
    run_packets(2, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || packet_count !== 32'd19) begin
      failures++;
      $display("FAIL drop_restart: got ok=%b left=%0d count=%0d, expected 1 0 19", ok, exp_q.size(), packet_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mon_pkts = 0;
    push_packet(4'd4);
    enable = 1'b1;
    ok = 1'b0;
    for (int cyc = 0; cyc < PLEN + PGAP + 60 && !ok; cyc++) begin
      @(negedge clk);
      if (valid && mon_pkts == 1 && mon_idx == 100) ok = 1'b1;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || {valid, sync, data, busy} !== 11'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: got reached=%b valid=%b sync=%b data=%h busy=%b, expected 1 0 0 00 0",
               ok, valid, sync, data, busy);
    end
    checks++;
    if (packet_count !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_count: got %0d, expected 0", packet_count);
    end
    exp_q.delete();
    mon_pkts = 0;
    push_packet(4'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_pkts(1, 20, ok);
    checks++;
    if (!ok || packet_count !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_restart: got started=%b count=%0d, expected 1 0", ok, packet_count);
    end
    enable = 1'b0;
    wait_idle(PLEN + PGAP + 50, ok);
    checks++;
    if (!ok || packet_count !== 32'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_finish: got ok=%b count=%0d left=%0d, expected 1 1 0", ok, packet_count, exp_q.size());
    end
  endtask

  task automatic test_gap0();
    int  idx0;
    int  pkts0;
    bit  prev_last;
    bit  hit;
    int  holes;
    bit  ok;
    do_reset();
    idx0      = -1;
    pkts0     = 0;
    prev_last = 1'b0;
    hit       = 1'b0;
    holes     = 0;
    enable0   = 1'b1;
    for (int cyc = 0; cyc < 2 * PLEN + 50; cyc++) begin
      @(negedge clk);
      if (prev_last) begin
        hit = 1'b1;
        checks++;
        if (valid0 !== 1'b1 || sync0 !== 1'b1 || data0 !== 8'h47) begin
          failures++;
          $display("FAIL gap0_junction: got valid=%b sync=%b data=%h, expected 1 1 47", valid0, sync0, data0);
        end
      end
      if (valid0) begin
        if (sync0) begin
          idx0 = 0;
          pkts0++;
        end else begin
          idx0++;
        end
        if (pkts0 == 2 && idx0 == 3) begin
          checks++;
          if (data0 !== 8'h11) begin
            failures++;
            $display("FAIL gap0_cc: got byte3=%h, expected 11", data0);
          end
        end
      end else if (pkts0 == 1) begin
        holes++;
      end
      prev_last = valid0 && pkts0 == 1 && idx0 == PLEN - 1;
      if (pkts0 >= 2 && idx0 >= 3) break;
    end
    enable0 = 1'b0;
    checks++;
    if (!hit || holes != 0) begin
      failures++;
      $display("FAIL gap0_continuous: got junction_seen=%b holes=%0d, expected 1 0", hit, holes);
    end
    ok = 1'b0;
    for (int i = 0; i < PLEN + 20; i++) begin
      @(negedge clk);
      if (!busy0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || packet_count0 !== 32'd2) begin
      failures++;
      $display("FAIL gap0_finish: got idle=%b count=%0d, expected 1 2", ok, packet_count0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_skip();
    test_skip_wrap();
    test_enable_drop();
    test_reset_mid();
    test_gap0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
